// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its funnel shifter.
// The mode encoding is the shifter's native 3-bit code: bit 2 selects left and bits [1:0] select the kind of shift.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_NOP     = 3'b000,
    MODE_LSR     = 3'b001,
    MODE_ASR     = 3'b010,
    MODE_ROR     = 3'b011,
    MODE_NOP_ALT = 3'b100,
    MODE_LSL     = 3'b101,
    MODE_ASL     = 3'b110,
    MODE_ROL     = 3'b111
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int DATA_W     = 16;
  localparam int MAX_PASS_N = 15;
  localparam int FULL_SHIFT = 16;

  function automatic logic is_rotate(input shift_mode_t mode);
    return (mode == MODE_ROR) || (mode == MODE_ROL);
  endfunction

  function automatic logic is_nop(input shift_mode_t mode);
    return (mode == MODE_NOP) || (mode == MODE_NOP_ALT);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Op request and result channels of the shift sequencer.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
// The source holds its payload stable while valid=1 and ready=0. valid never depends on ready.
interface shift_sequencer_if #(
  parameter int AMT_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic [2:0]       in_mode;
  logic [AMT_W-1:0] in_amount;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_z;
  logic             out_n;
  logic             out_c;

  modport master (
    output in_valid, in_data, in_mode, in_amount, out_ready,
    input  in_ready, out_valid, out_data, out_z, out_n, out_c
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_amount, out_ready,
    output in_ready, out_valid, out_data, out_z, out_n, out_c
  );

endinterface

// File: rtl/shifter.sv
// 16-bit combinational funnel shifter.
// Right modes shift {fill, data} right by n. Left modes shift {data, fill} right by 16-n, which is the same as shifting left by n.
module shifter
  import shift_pkg::*;
(
  input  logic [15:0] i_data,
  input  shift_mode_t i_mode,
  input  logic [3:0]  i_n,
  output logic [15:0] o_data
);

  logic [15:0] w_fill;
  logic [4:0]  w_left_sh;

  assign w_left_sh = 5'(FULL_SHIFT) - {1'b0, i_n};

  always_comb begin
    w_fill = '0;
    o_data = i_data;
    case (i_mode)
      MODE_LSR: begin
        w_fill = '0;
        o_data = 16'({w_fill, i_data} >> i_n);
      end
      MODE_ASR: begin
        w_fill = {16{i_data[15]}};
        o_data = 16'({w_fill, i_data} >> i_n);
      end
      MODE_ROR: begin
        w_fill = i_data;
        o_data = 16'({w_fill, i_data} >> i_n);
      end
      MODE_LSL, MODE_ASL: begin
        w_fill = '0;
        o_data = 16'({i_data, w_fill} >> w_left_sh);
      end
      MODE_ROL: begin
        w_fill = i_data;
        o_data = 16'({i_data, w_fill} >> w_left_sh);
      end
      default: begin
        w_fill = '0;
        o_data = i_data;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Execute-stage front end for the funnel shifter. It accepts one shift op, splits the amount into passes of at most 15 positions, and returns the result with Z/N/C flags.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus,
  output seq_state_t       o_dbg_state
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;

  logic [15:0] r_acc;
  shift_mode_t r_mode;
  logic [4:0]  r_rem;

  logic [15:0] r_out_data;
  logic        r_out_z;
  logic        r_out_n;
  logic        r_out_c;

  shift_mode_t w_mode_in;
  logic [4:0]  w_eff;
  logic [3:0]  w_pass_n;
  logic [3:0]  w_lsl_idx;
  logic [3:0]  w_lsr_idx;
  logic [15:0] w_shift_out;
  logic        w_pass_c;
  logic        w_accept;
  logic        w_last_pass;
  logic        w_load_out;
  logic [15:0] w_final_data;
  logic        w_final_c;

  // Arithmetic left is issued as logical left, so the shifter's 110 path stays unused.
  always_comb begin
    w_mode_in = shift_mode_t'(bus.in_mode);
    if (w_mode_in == MODE_ASL) begin
      w_mode_in = MODE_LSL;
    end
  end

  always_comb begin
    w_eff = '0;
    if (is_nop(w_mode_in)) begin
      w_eff = '0;
    end else if (is_rotate(w_mode_in)) begin
      w_eff = {1'b0, bus.in_amount[3:0]};
    end else if (bus.in_amount > AMT_W'(FULL_SHIFT)) begin
      w_eff = 5'(FULL_SHIFT);
    end else begin
      w_eff = 5'(bus.in_amount);
    end
  end

  assign w_pass_n    = (r_rem > 5'(MAX_PASS_N)) ? 4'(MAX_PASS_N) : r_rem[3:0];
  assign w_last_pass = (r_rem == {1'b0, w_pass_n});
  assign w_lsr_idx   = w_pass_n - 4'd1;
  assign w_lsl_idx   = 4'(5'(FULL_SHIFT) - {1'b0, w_pass_n});

  shifter u_shifter (
    .i_data (r_acc),
    .i_mode (r_mode),
    .i_n    (w_pass_n),
    .o_data (w_shift_out)
  );

  // Carry is the last bit to leave the word in this pass.
  always_comb begin
    w_pass_c = 1'b0;
    case (r_mode)
      MODE_LSR, MODE_ASR: w_pass_c = r_acc[w_lsr_idx];
      MODE_LSL:           w_pass_c = r_acc[w_lsl_idx];
      MODE_ROR:           w_pass_c = w_shift_out[15];
      MODE_ROL:           w_pass_c = w_shift_out[0];
      default:            w_pass_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (w_eff == 5'd0) ? DONE : PASS;
        end
      end
      PASS: begin
        if (w_last_pass) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The result register loads only on the way into DONE, so it holds still under backpressure.
  assign w_load_out   = (w_state_next == DONE) && (r_state != DONE);
  assign w_final_data = (r_state == IDLE) ? bus.in_data : w_shift_out;
  assign w_final_c    = (r_state == IDLE) ? 1'b0 : w_pass_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_mode     <= MODE_NOP;
      r_rem      <= '0;
      r_out_data <= '0;
      r_out_z    <= 1'b0;
      r_out_n    <= 1'b0;
      r_out_c    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc  <= bus.in_data;
        r_mode <= w_mode_in;
        r_rem  <= w_eff;
      end else if (r_state == PASS) begin
        r_acc <= w_shift_out;
        r_rem <= r_rem - {1'b0, w_pass_n};
      end
      if (w_load_out) begin
        r_out_data <= w_final_data;
        r_out_z    <= (w_final_data == 16'h0000);
        r_out_n    <= w_final_data[15];
        r_out_c    <= w_final_c;
      end
    end
  end

  assign bus.out_data = r_out_data;
  assign bus.out_z    = r_out_z;
  assign bus.out_n    = r_out_n;
  assign bus.out_c    = r_out_c;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and random ops checked against a bit-at-a-time reference model, plus backpressure and mid-op reset.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int W = 19;

  logic       clk;
  logic       rst_n;
  seq_state_t dbg_state;
  int         n_checks;
  int         n_miss;
  logic [W-1:0] exp_q[$];

  shift_sequencer_if #(.AMT_W(8)) bus ();

  shift_sequencer #(.AMT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: one position per step, carry = bit that just left
  function automatic int model_eff(input logic [2:0] m, input logic [7:0] a);
    if (m[1:0] == 2'b00) return 0;
    if (m[1:0] == 2'b11) return int'(a) % 16;
    return (a > 8'd16) ? 16 : int'(a);
  endfunction

  function automatic int model_lat(input int eff);
    if (eff == 0) return 1;
    if (eff <= 15) return 2;
    return 3;
  endfunction

  function automatic logic [W-1:0] model_result(input logic [15:0] d, input logic [2:0] m,
                                                input logic [7:0] a);
    logic [15:0] x;
    logic        c;
    int          eff;
    x = d;
    c = 1'b0;
    eff = model_eff(m, a);
    for (int i = 0; i < eff; i++) begin
      case (m)
        3'b001: begin c = x[0];  x = {1'b0, x[15:1]}; end
        3'b010: begin c = x[0];  x = {x[15], x[15:1]}; end
        3'b101, 3'b110: begin c = x[15]; x = {x[14:0], 1'b0}; end
        3'b011: begin x = {x[0], x[15:1]}; c = x[15]; end
        3'b111: begin x = {x[14:0], x[15]}; c = x[0]; end
        default: begin end
      endcase
    end
    return {x, (x == 16'h0000), x[15], c};
  endfunction

  // driver: issue one op, check latency, result and the return to IDLE
  task automatic run_op(input logic [15:0] d, input logic [2:0] m, input logic [7:0] a,
                        input logic [W-1:0] exp_res, input int exp_lat, input string name);
    int           wait_cyc;
    int           lat;
    logic [W-1:0] want;
    logic [W-1:0] got;
    exp_q.push_back(exp_res);
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.in_amount = a;
    bus.in_valid  = 1'b1;
    wait_cyc = 0;
    while (!bus.in_ready && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
      n_miss++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'($urandom);
    bus.in_mode   = 3'($urandom_range(0, 7));
    bus.in_amount = 8'($urandom_range(0, 255));
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    want = exp_q.pop_front();
    got  = {bus.out_data, bus.out_z, bus.out_n, bus.out_c};
    n_checks++;
    if (lat !== exp_lat) begin
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      n_miss++;
    end
    n_checks++;
    if (got !== want) begin
      $display("FAIL %s result: data=%h z=%b n=%b c=%b required data=%h z=%b n=%b c=%b",
               name, got[18:3], got[2], got[1], got[0], want[18:3], want[2], want[1], want[0]);
      n_miss++;
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1",
               name, bus.out_valid, bus.in_ready);
      n_miss++;
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = '0;
    bus.in_amount = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_z, bus.out_n, bus.out_c} !==
        {1'b0, 1'b1, 16'h0000, 3'b000} || dbg_state !== IDLE) begin
      $display("FAIL reset: out_valid=%b in_ready=%b data=%h znc=%b%b%b state=%0d required 0 1 0000 000 IDLE",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_z, bus.out_n, bus.out_c, dbg_state);
      n_miss++;
    end
  endtask

  task automatic test_directed();
    run_op(16'h8001, 3'b001, 8'd1,   {16'h4000, 3'b001}, 2, "lsr_8001_1");
    run_op(16'h8000, 3'b010, 8'd20,  {16'hFFFF, 3'b011}, 3, "asr_8000_20");
    run_op(16'h0001, 3'b101, 8'd16,  {16'h0000, 3'b101}, 3, "lsl_0001_16");
    run_op(16'h1234, 3'b111, 8'd36,  {16'h2341, 3'b001}, 2, "rol_1234_36");
    run_op(16'h0001, 3'b011, 8'd1,   {16'h8000, 3'b011}, 2, "ror_0001_1");
    run_op(16'hABCD, 3'b001, 8'd0,   {16'hABCD, 3'b010}, 1, "lsr_abcd_0");
    run_op(16'h4001, 3'b110, 8'd1,   {16'h8002, 3'b010}, 2, "asl_4001_1");
    run_op(16'h1234, 3'b100, 8'd9,   {16'h1234, 3'b000}, 1, "nop_1234_9");
    run_op(16'h00F0, 3'b011, 8'd16,  {16'h00F0, 3'b000}, 1, "ror_00f0_16");
    run_op(16'hFFFF, 3'b001, 8'd255, {16'h0000, 3'b101}, 3, "lsr_ffff_255");
    run_op(16'h0003, 3'b111, 8'd15,  {16'h8001, 3'b011}, 2, "rol_0003_15");
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [2:0]  m;
    logic [7:0]  a;
    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 20));
      else a = 8'($urandom_range(0, 255));
      run_op(d, m, a, model_result(d, m, a), model_lat(model_eff(m, a)), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] want1;
    logic [W-1:0] want2;
    int           lat;
    want1 = model_result(16'h00F0, 3'b101, 8'd4);
    want2 = model_result(16'h8001, 3'b001, 8'd1);
    bus.out_ready = 1'b0;
    bus.in_data   = 16'h00F0;
    bus.in_mode   = 3'b101;
    bus.in_amount = 8'd4;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_data   = 16'h8001;
    bus.in_mode   = 3'b001;
    bus.in_amount = 8'd1;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.out_data, bus.out_z, bus.out_n, bus.out_c} !== want1 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        $display("FAIL bp_hold cycle %0d: data=%h znc=%b%b%b valid=%b ready=%b required data=%h znc=%b valid=1 ready=0",
                 i, bus.out_data, bus.out_z, bus.out_n, bus.out_c, bus.out_valid, bus.in_ready,
                 want1[18:3], want1[2:0]);
        n_miss++;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
      n_miss++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || dbg_state !== PASS) begin
      $display("FAIL bp_queued_accept: in_ready=%b state=%0d required 0 PASS", bus.in_ready, dbg_state);
      n_miss++;
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_z, bus.out_n, bus.out_c} !== {1'b1, want2}) begin
      $display("FAIL bp_queued_result: valid=%b data=%h znc=%b%b%b required 1 %h %b",
               bus.out_valid, bus.out_data, bus.out_z, bus.out_n, bus.out_c, want2[18:3], want2[2:0]);
      n_miss++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bus.in_data   = 16'h8000;
    bus.in_mode   = 3'b010;
    bus.in_amount = 8'd16;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_z, bus.out_n, bus.out_c} !==
        {1'b0, 1'b1, 16'h0000, 3'b000}) begin
      $display("FAIL abort_reset: out_valid=%b in_ready=%b data=%h znc=%b%b%b required 0 1 0000 000",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_z, bus.out_n, bus.out_c);
      n_miss++;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        $display("FAIL abort_no_result cycle %0d: out_valid=%b required 0", i, bus.out_valid);
        n_miss++;
      end
    end
    run_op(16'h0F0F, 3'b111, 8'd8, model_result(16'h0F0F, 3'b111, 8'd8), 2, "after_abort");
  endtask

  initial begin
    n_checks = 0;
    n_miss   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
